// File: rtl/mips_alu_pkg.sv
// Shared constants for the ALU result stage: compare function codes and
// the packed result-entry width.
package mips_alu_pkg;

    localparam logic [2:0] CMP_NE  = 3'b000;
    localparam logic [2:0] CMP_EQ  = 3'b001;
    localparam logic [2:0] CMP_LT  = 3'b010;
    localparam logic [2:0] CMP_LTZ = 3'b101;
    localparam logic [2:0] CMP_LEZ = 3'b110;
    localparam logic [2:0] CMP_GTZ = 3'b111;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned RD_W    = 5;
    localparam int unsigned ENTRY_W = DATA_W + RD_W;

endpackage

// File: rtl/alu_result_stage_if.sv
// EX-to-MEM beat bus of the ALU result stage, including flush and trap signals.
interface alu_result_stage_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_s;
    logic        alu_z;
    logic        alu_v;
    logic        alu_n;
    logic        in_sel_cmp;
    logic [2:0]  in_cmp_op;
    logic        in_trap_en;
    logic [4:0]  in_rd;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        exc_pending;
    logic [31:0] exc_epc;
    logic        exc_ack;

    modport slave (
        input  in_valid, alu_s, alu_z, alu_v, alu_n, in_sel_cmp, in_cmp_op, in_trap_en,
        input  in_rd, in_pc, flush, out_ready, exc_ack,
        output in_ready, out_valid, out_data, out_rd, exc_pending, exc_epc
    );

    modport master (
        output in_valid, alu_s, alu_z, alu_v, alu_n, in_sel_cmp, in_cmp_op, in_trap_en,
        output in_rd, in_pc, flush, out_ready, exc_ack,
        input  in_ready, out_valid, out_data, out_rd, exc_pending, exc_epc
    );

endinterface

// File: rtl/alu_skid_fifo.sv
// Small skid FIFO holding {result, rd} entries; not_full is registered so
// the upstream ready never depends combinationally on the downstream pop.
module alu_skid_fifo
    import mips_alu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic               pop,
    input  logic               flush,
    output logic [ENTRY_W-1:0] rdata,
    output logic               valid,
    output logic               not_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               not_full_q, not_full_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // Keep the read pointer so out_data holds across the flush.
            wr_ptr_d = rd_ptr_q;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
        not_full_d = count_d < CNT_W'(DEPTH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            not_full_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            not_full_q <= not_full_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata    = mem_q[rd_ptr_q];
    assign valid    = count_q != '0;
    assign not_full = not_full_q;

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: selects sum or compare bit, traps on enabled signed
// overflow, and buffers results towards MEM through a 2-entry skid FIFO.
module alu_result_stage
    import mips_alu_pkg::*;
#(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] RESET_EPC = 32'h0000_0000
) (
    input logic               clk,
    input logic               reset,
    alu_result_stage_if.slave bus
);

    logic               cmp_bit;
    logic [31:0]        result;
    logic               accept;
    logic               trap;
    logic               push;
    logic               pop;
    logic               fifo_valid;
    logic               fifo_not_full;
    logic [ENTRY_W-1:0] head;
    logic               exc_pending_q, exc_pending_d;
    logic [31:0]        exc_epc_q, exc_epc_d;

    always_comb begin
        cmp_bit = 1'b0;
        case (bus.in_cmp_op)
            CMP_EQ:          cmp_bit = bus.alu_z;
            CMP_NE:          cmp_bit = ~bus.alu_z;
            CMP_LT, CMP_LTZ: cmp_bit = bus.alu_n;
            CMP_LEZ:         cmp_bit = bus.alu_n | bus.alu_z;
            CMP_GTZ:         cmp_bit = ~bus.alu_n & ~bus.alu_z;
            default:         cmp_bit = 1'b0;
        endcase
        result = bus.in_sel_cmp ? {31'b0, cmp_bit} : bus.alu_s;
    end

    // Both terms of in_ready are flops, so it never sees out_ready directly.
    assign bus.in_ready = fifo_not_full & ~exc_pending_q;
    assign accept       = bus.in_valid & bus.in_ready;
    assign trap         = accept & bus.in_trap_en & bus.alu_v;
    assign push         = accept & ~trap;
    assign pop          = fifo_valid & bus.out_ready;

    alu_skid_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .wdata    ({result, bus.in_rd}),
        .pop      (pop),
        .flush    (bus.flush),
        .rdata    (head),
        .valid    (fifo_valid),
        .not_full (fifo_not_full)
    );

    assign bus.out_valid = fifo_valid;
    assign bus.out_data  = head[ENTRY_W-1:RD_W];
    assign bus.out_rd    = head[RD_W-1:0];

    // A trap can only be accepted while nothing is pending, so it never races an ack.
    always_comb begin
        exc_pending_d = exc_pending_q;
        exc_epc_d     = exc_epc_q;
        if (trap) begin
            exc_pending_d = 1'b1;
            exc_epc_d     = bus.in_pc;
        end else if (bus.exc_ack) begin
            exc_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exc_pending_q <= 1'b0;
            exc_epc_q     <= RESET_EPC;
        end else begin
            exc_pending_q <= exc_pending_d;
            exc_epc_q     <= exc_epc_d;
        end
    end

    assign bus.exc_pending = exc_pending_q;
    assign bus.exc_epc     = exc_epc_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_alu_result_stage;
    import mips_alu_pkg::*;

    localparam logic [31:0] RESET_EPC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    beat_t       q[$];
    logic        m_pending;
    logic [31:0] m_epc;

    alu_result_stage_if bus();

    alu_result_stage #(
        .DEPTH     (2),
        .RESET_EPC (RESET_EPC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_result(logic sel, logic [2:0] op, logic [31:0] s,
                                                 logic z, logic n);
        logic c;
        c = 1'b0;
        if (!sel) return s;
        case (op)
            3'b001:         c = z;
            3'b000:         c = !z;
            3'b010, 3'b101: c = n;
            3'b110:         c = n || z;
            3'b111:         c = !n && !z;
            default:        c = 1'b0;
        endcase
        return {31'b0, c};
    endfunction

    function automatic logic m_ready();
        return (q.size() < 2) && !m_pending;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pending = 1'b0;
        m_epc     = RESET_EPC;
    endtask

    task automatic idle();
        bus.in_valid   = 1'b0;
        bus.alu_s      = '0;
        bus.alu_z      = 1'b0;
        bus.alu_v      = 1'b0;
        bus.alu_n      = 1'b0;
        bus.in_sel_cmp = 1'b0;
        bus.in_cmp_op  = '0;
        bus.in_trap_en = 1'b0;
        bus.in_rd      = '0;
        bus.in_pc      = '0;
        bus.flush      = 1'b0;
        bus.exc_ack    = 1'b0;
        bus.out_ready  = 1'b0;
    endtask

    task automatic drive(logic [31:0] s, logic z, logic v, logic n, logic sel, logic [2:0] op,
                         logic ten, logic [4:0] rd, logic [31:0] pc);
        bus.in_valid   = 1'b1;
        bus.alu_s      = s;
        bus.alu_z      = z;
        bus.alu_v      = v;
        bus.alu_n      = n;
        bus.in_sel_cmp = sel;
        bus.in_cmp_op  = op;
        bus.in_trap_en = ten;
        bus.in_rd      = rd;
        bus.in_pc      = pc;
    endtask

    // One clock: model consumes the pre-edge inputs, outputs settle 1 time unit after the edge.
    task automatic tick();
        logic        accept, trap, pop, flush, ack;
        logic [31:0] pc;
        beat_t       b;
        pop    = (q.size() > 0) && bus.out_ready;
        accept = bus.in_valid && m_ready();
        trap   = accept && bus.in_trap_en && bus.alu_v;
        flush  = bus.flush;
        ack    = bus.exc_ack;
        pc     = bus.in_pc;
        b.data = model_result(bus.in_sel_cmp, bus.in_cmp_op, bus.alu_s, bus.alu_z, bus.alu_n);
        b.rd   = bus.in_rd;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (accept && !trap) q.push_back(b);
        end
        if (trap) begin
            m_pending = 1'b1;
            m_epc     = pc;
        end else if (ack) begin
            m_pending = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_rd, bus.exc_pending, bus.exc_epc} !==
            {1'b0, 32'h0, 5'h0, 1'b0, RESET_EPC}) begin
            errors++;
            $display("FAIL reset_outputs got v=%0b d=%h rd=%0d p=%0b epc=%h", bus.out_valid,
                     bus.out_data, bus.out_rd, bus.exc_pending, bus.exc_epc);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release got in_ready=%0b out_valid=%0b want 1 0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid_stream();
        idle();
        drive(32'h0000_00a1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b0, 1'b0, 5'd1, 32'h100);
        tick();
        drive(32'h0000_00a2, 1'b0, 1'b0, 1'b0, 1'b0, 3'b0, 1'b0, 5'd2, 32'h104);
        tick();
        idle();
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.out_data} !== {2'b10, 32'h0000_00a1}) begin
            errors++;
            $display("FAIL mid_fill got v=%0b rdy=%0b d=%h want 1 0 000000a1", bus.out_valid,
                     bus.in_ready, bus.out_data);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.out_valid, bus.exc_pending, bus.exc_epc} !== {2'b00, RESET_EPC}) begin
            errors++;
            $display("FAIL mid_reset_full got v=%0b p=%0b epc=%h want 0 0 %h", bus.out_valid,
                     bus.exc_pending, bus.exc_epc, RESET_EPC);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(32'h0000_00b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b0, 1'b0, 5'd3, 32'h200);
        tick();
        drive(32'h7fff_ffff, 1'b0, 1'b1, 1'b0, 1'b0, 3'b0, 1'b1, 5'd4, 32'h1234_5678);
        tick();
        idle();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.out_valid, bus.exc_pending, bus.exc_epc} !== {2'b00, RESET_EPC}) begin
            errors++;
            $display("FAIL mid_reset_trap got v=%0b p=%0b epc=%h want 0 0 %h", bus.out_valid,
                     bus.exc_pending, bus.exc_epc, RESET_EPC);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_ready got %0b want 1", bus.in_ready);
        end
    endtask

    task automatic test_overflow_trap();
        idle();
        bus.out_ready = 1'b1;
        drive(32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 3'b0, 1'b1, 5'd9, 32'h0040_0010);
        tick();
        checks++;
        if ({bus.out_valid, bus.exc_pending, bus.in_ready, bus.exc_epc} !==
            {3'b010, 32'h0040_0010}) begin
            errors++;
            $display("FAIL trap_latch got v=%0b p=%0b rdy=%0b epc=%h want 0 1 0 00400010",
                     bus.out_valid, bus.exc_pending, bus.in_ready, bus.exc_epc);
        end
        drive(32'h0000_0055, 1'b0, 1'b0, 1'b0, 1'b0, 3'b0, 1'b0, 5'd2, 32'h0040_0014);
        tick();
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b00) begin
            errors++;
            $display("FAIL trap_blocks_input got v=%0b rdy=%0b want 0 0", bus.out_valid,
                     bus.in_ready);
        end
        idle();
        bus.out_ready = 1'b1;
        bus.exc_ack   = 1'b1;
        tick();
        checks++;
        if ({bus.exc_pending, bus.in_ready, bus.exc_epc} !== {2'b01, 32'h0040_0010}) begin
            errors++;
            $display("FAIL trap_ack got p=%0b rdy=%0b epc=%h want 0 1 00400010",
                     bus.exc_pending, bus.in_ready, bus.exc_epc);
        end
        tick();
        checks++;
        if ({bus.exc_pending, bus.exc_epc} !== {1'b0, 32'h0040_0010}) begin
            errors++;
            $display("FAIL idle_ack got p=%0b epc=%h want 0 00400010", bus.exc_pending,
                     bus.exc_epc);
        end
        bus.exc_ack = 1'b0;
        drive(32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 3'b0, 1'b0, 5'd7, 32'h0040_0020);
        tick();
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_rd, bus.exc_pending} !==
            {1'b1, 32'h8000_0000, 5'd7, 1'b0}) begin
            errors++;
            $display("FAIL unsigned_v_ignored got v=%0b d=%h rd=%0d p=%0b want 1 80000000 7 0",
                     bus.out_valid, bus.out_data, bus.out_rd, bus.exc_pending);
        end
        idle();
        bus.out_ready = 1'b1;
        tick();
    endtask

    task automatic test_compare_sweep();
        logic [2:0] ops [11] = '{3'b001, 3'b000, 3'b110, 3'b111, 3'b010, 3'b101, 3'b111,
                                 3'b011, 3'b111, 3'b110, 3'b100};
        logic       zs  [11] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        logic       ns  [11] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1};
        logic       exp [11] = '{1, 0, 1, 0, 1, 1, 0, 0, 1, 0, 0};
        logic [31:0] s;
        idle();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            s = $urandom() | 32'hdead_0000;
            drive(s, zs[i], 1'b0, ns[i], 1'b1, ops[i], 1'b0, 5'(i), 32'h300 + 32'(i));
            tick();
            checks++;
            if ({bus.out_valid, bus.out_data, bus.out_rd} !== {1'b1, 31'b0, exp[i], 5'(i)}) begin
                errors++;
                $display("FAIL cmp_%0d op=%b z=%0b n=%0b got v=%0b d=%h want 1 %h", i, ops[i],
                         zs[i], ns[i], bus.out_valid, bus.out_data, {31'b0, exp[i]});
            end
        end
        idle();
        bus.out_ready = 1'b1;
        tick();
    endtask

    task automatic test_back_pressure();
        idle();
        drive(32'h11, 1'b0, 1'b0, 1'b0, 1'b0, 3'b0, 1'b0, 5'd1, 32'h400);
        tick();
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_data} !== {2'b11, 32'h11}) begin
            errors++;
            $display("FAIL bp_first got rdy=%0b v=%0b d=%h want 1 1 11", bus.in_ready,
                     bus.out_valid, bus.out_data);
        end
        drive(32'h22, 1'b0, 1'b0, 1'b0, 1'b0, 3'b0, 1'b0, 5'd2, 32'h404);
        tick();
        drive(32'h33, 1'b0, 1'b0, 1'b0, 1'b0, 3'b0, 1'b0, 5'd3, 32'h408);
        tick();
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_data} !== {2'b01, 32'h11}) begin
            errors++;
            $display("FAIL bp_full got rdy=%0b v=%0b d=%h want 0 1 11", bus.in_ready,
                     bus.out_valid, bus.out_data);
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if ({bus.in_ready, bus.out_data, bus.out_rd} !== {1'b1, 32'h22, 5'd2}) begin
            errors++;
            $display("FAIL bp_pop1 got rdy=%0b d=%h rd=%0d want 1 22 2", bus.in_ready,
                     bus.out_data, bus.out_rd);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_rd} !== {1'b1, 32'h33, 5'd3}) begin
            errors++;
            $display("FAIL bp_third got v=%0b d=%h rd=%0d want 1 33 3", bus.out_valid,
                     bus.out_data, bus.out_rd);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain got v=%0b want 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] sent [8];
        idle();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sent[i] = $urandom();
            drive(sent[i], 1'b0, 1'b0, 1'b0, 1'b0, 3'b0, 1'b0, 5'(i + 10), 32'h500);
            tick();
            checks++;
            if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_rd} !==
                {2'b11, sent[i], 5'(i + 10)}) begin
                errors++;
                $display("FAIL b2b_%0d got rdy=%0b v=%0b d=%h want 1 1 %h", i, bus.in_ready,
                         bus.out_valid, bus.out_data, sent[i]);
            end
        end
        idle();
        drive(32'haa, 1'b0, 1'b0, 1'b0, 1'b0, 3'b0, 1'b0, 5'd1, 32'h600);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        drive(32'hbb, 1'b0, 1'b0, 1'b0, 1'b0, 3'b0, 1'b0, 5'd2, 32'h604);
        tick();
        bus.out_ready = 1'b1;
        drive(32'hcc, 1'b0, 1'b0, 1'b0, 1'b0, 3'b0, 1'b0, 5'd3, 32'h608);
        tick();
        checks++;
        if ({bus.out_valid, bus.out_data, bus.in_ready} !== {1'b1, 32'hbb, 1'b1}) begin
            errors++;
            $display("FAIL full_pushpop got v=%0b d=%h rdy=%0b want 1 bb 1", bus.out_valid,
                     bus.out_data, bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_rd} !== {1'b1, 32'hcc, 5'd3}) begin
            errors++;
            $display("FAIL one_pushpop got v=%0b d=%h rd=%0d want 1 cc 3", bus.out_valid,
                     bus.out_data, bus.out_rd);
        end
        tick();
    endtask

    task automatic test_flush();
        idle();
        drive(32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b0, 1'b0, 5'd1, 32'h700);
        tick();
        drive(32'h2, 1'b0, 1'b0, 1'b0, 1'b0, 3'b0, 1'b0, 5'd2, 32'h704);
        tick();
        drive(32'h3, 1'b0, 1'b0, 1'b0, 1'b0, 3'b0, 1'b0, 5'd3, 32'h708);
        bus.flush = 1'b1;
        tick();
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL flush_full got v=%0b rdy=%0b want 0 1", bus.out_valid, bus.in_ready);
        end
        idle();
        drive(32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 3'b0, 1'b0, 5'd4, 32'h70c);
        tick();
        drive(32'h5, 1'b0, 1'b0, 1'b0, 1'b0, 3'b0, 1'b0, 5'd5, 32'h710);
        bus.flush = 1'b1;
        tick();
        idle();
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drops_push got v=%0b want 0", bus.out_valid);
        end
        drive(32'h6, 1'b0, 1'b0, 1'b0, 1'b0, 3'b0, 1'b0, 5'd6, 32'h714);
        tick();
        drive(32'h7fff_0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b0, 1'b1, 5'd7, 32'h0040_0abc);
        tick();
        idle();
        bus.flush = 1'b1;
        tick();
        checks++;
        if ({bus.out_valid, bus.exc_pending, bus.exc_epc} !== {2'b01, 32'h0040_0abc}) begin
            errors++;
            $display("FAIL flush_keeps_trap got v=%0b p=%0b epc=%h want 0 1 00400abc",
                     bus.out_valid, bus.exc_pending, bus.exc_epc);
        end
        idle();
        bus.exc_ack = 1'b1;
        tick();
        idle();
        drive(32'h8, 1'b0, 1'b0, 1'b0, 1'b0, 3'b0, 1'b0, 5'd8, 32'h720);
        tick();
        drive(32'h8000_0001, 1'b0, 1'b1, 1'b1, 1'b0, 3'b0, 1'b1, 5'd9, 32'h0040_0def);
        bus.flush = 1'b1;
        tick();
        checks++;
        if ({bus.out_valid, bus.exc_pending, bus.exc_epc} !== {2'b01, 32'h0040_0def}) begin
            errors++;
            $display("FAIL flush_trap_same_cycle got v=%0b p=%0b epc=%h want 0 1 00400def",
                     bus.out_valid, bus.exc_pending, bus.exc_epc);
        end
        idle();
        bus.exc_ack = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom(), 1'($urandom()), ($urandom_range(7) == 0), 1'($urandom()),
                  1'($urandom()), 3'($urandom()), 1'($urandom()), 5'($urandom()), $urandom());
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.out_ready = 1'($urandom());
            bus.flush     = ($urandom_range(19) == 0);
            bus.exc_ack   = ($urandom_range(2) == 0);
            tick();
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.exc_pending, bus.exc_epc} !==
                {(q.size() != 0), m_ready(), m_pending, m_epc}) begin
                errors++;
                $display("FAIL rand_ctrl_%0d got v=%0b rdy=%0b p=%0b epc=%h want %0b %0b %0b %h",
                         i, bus.out_valid, bus.in_ready, bus.exc_pending, bus.exc_epc,
                         (q.size() != 0), m_ready(), m_pending, m_epc);
            end
            if (q.size() != 0) begin
                checks++;
                if ({bus.out_data, bus.out_rd} !== q[0]) begin
                    errors++;
                    $display("FAIL rand_data_%0d got d=%h rd=%0d want d=%h rd=%0d", i,
                             bus.out_data, bus.out_rd, q[0].data, q[0].rd);
                end
            end
        end
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "simulation timeout");
    end

    initial begin
        test_reset();
        test_reset_mid_stream();
        test_overflow_trap();
        test_compare_sweep();
        test_back_pressure();
        test_back_to_back();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
